// File: rtl/fft_bfii_pkg.sv
// Shared types and helpers for the radix-2^2 SDF type-II butterfly.
// Phase codes are the two counter bits above the intra-phase sample index.
package fft_bfii_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'b00,
        BFLY     = 2'b01,
        FILL_ROT = 2'b10,
        BFLY_ROT = 2'b11
    } phase_e;

    // Ceiling log2 for elaboration-time sizing; returns 0 for an input of 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/shift_reg.sv
// Fixed-depth sample delay line; data is not reset and shifts every clock.
module shift_reg #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH > 1) begin : g_chain
        logic [DEPTH*WIDTH-1:0] pipe;

        always_ff @(posedge clk) begin
            pipe <= {pipe[(DEPTH-1)*WIDTH-1:0], d};
        end

        assign q = pipe[DEPTH*WIDTH-1 -: WIDTH];
    end else begin : g_single
        always_ff @(posedge clk) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fft_bfii.sv
// Radix-2^2 SDF type-II butterfly with built-in -j rotation and feedback delay.
// Control (frame counter and carry chain) is derived locally from carry_in.
module fft_bfii
    import fft_bfii_pkg::*;
#(
    parameter int unsigned WIDTH         = 24,
    parameter int unsigned SHIFT_REG_LEN = 256
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    carry_in,
    output logic                    carry_out,
    input  logic signed [WIDTH-1:0] x_re_i,
    input  logic signed [WIDTH-1:0] x_im_i,
    output logic signed [WIDTH-1:0] z_re_o,
    output logic signed [WIDTH-1:0] z_im_o
);

    localparam int unsigned L  = SHIFT_REG_LEN;
    localparam int unsigned K  = clog2(SHIFT_REG_LEN);
    localparam int unsigned CW = K + 2;

    logic [CW-1:0]           ctr;
    logic [L:0]              carry_sr;
    phase_e                  phase;
    logic                    sel;
    logic                    rot;
    logic signed [WIDTH-1:0] xr_re;
    logic signed [WIDTH-1:0] xr_im;
    logic signed [WIDTH-1:0] sr_re;
    logic signed [WIDTH-1:0] sr_im;
    logic signed [WIDTH-1:0] dl_re;
    logic signed [WIDTH-1:0] dl_im;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;

    // Frame counter: wraps mod 4L, any carry gap restarts the frame.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            ctr <= '0;
        end else if (carry_in) begin
            ctr <= ctr + CW'(1);
        end else begin
            ctr <= '0;
        end
    end

    always_comb begin
        phase = phase_e'(ctr[K+1:K]);
        sel   = 1'b0;
        rot   = 1'b0;
        case (phase)
            BFLY:     sel = 1'b1;
            BFLY_ROT: begin
                sel = 1'b1;
                rot = 1'b1;
            end
            default:  sel = 1'b0;
        endcase
    end

    // Trivial -j rotation followed by the add/sub butterfly, all wrapping.
    always_comb begin
        xr_re  = x_re_i;
        xr_im  = x_im_i;
        out_re = sr_re;
        out_im = sr_im;
        dl_re  = xr_re;
        dl_im  = xr_im;
        if (rot) begin
            xr_re = x_im_i;
            xr_im = -x_re_i;
        end
        if (sel) begin
            out_re = xr_re + sr_re;
            out_im = xr_im + sr_im;
            dl_re  = sr_re - xr_re;
            dl_im  = sr_im - xr_im;
        end else begin
            dl_re  = xr_re;
            dl_im  = xr_im;
        end
    end

    if (L > 1) begin : g_delay_line
        shift_reg #(
            .WIDTH (WIDTH),
            .DEPTH (L)
        ) u_sr_re (
            .clk (clk),
            .d   (dl_re),
            .q   (sr_re)
        );

        shift_reg #(
            .WIDTH (WIDTH),
            .DEPTH (L)
        ) u_sr_im (
            .clk (clk),
            .d   (dl_im),
            .q   (sr_im)
        );
    end else begin : g_delay_reg
        always_ff @(posedge clk) begin
            sr_re <= dl_re;
            sr_im <= dl_im;
        end
    end

    // Carry chain matches the L+1 cycle input-to-output latency.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            carry_sr <= '0;
        end else begin
            carry_sr <= {carry_sr[L-1:0], carry_in};
        end
    end

    assign carry_out = carry_sr[L];

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            z_re_o <= '0;
            z_im_o <= '0;
        end else begin
            z_re_o <= out_re;
            z_im_o <= out_im;
        end
    end

endmodule

// File: tb/tb_fft_bfii.sv
// Bench for fft_bfii: directed vectors at WIDTH=8 (L=2, L=1) and random
// frames at WIDTH=24 (L=1,4,256) checked against a radix-2 frame model.
module tb_fft_bfii;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 24;
    localparam int unsigned N  = 3072;

    typedef struct {
        logic carry;
        int   re;
        int   im;
        logic co;
        int   zre;
        int   zim;
    } vec_t;

    logic clk = 1'b0;
    logic srst_n;
    always #5 clk = ~clk;

    logic                 d2_carry, d2_co;
    logic signed [DW-1:0] d2_re, d2_im, d2_zre, d2_zim;
    logic                 d1_carry, d1_co;
    logic signed [DW-1:0] d1_re, d1_im, d1_zre, d1_zim;
    logic                 r_carry;
    logic signed [RW-1:0] r_re, r_im;
    logic signed [RW-1:0] r_zre [3];
    logic signed [RW-1:0] r_zim [3];
    logic                 r_co  [3];

    int checks = 0;
    int errors = 0;
    int lens [3] = '{1, 4, 256};
    int xin_re [N];
    int xin_im [N];
    int exp_re [3][N];
    int exp_im [3][N];
    int ridx   [3];
    vec_t tbl[$];

    fft_bfii #(.WIDTH(DW), .SHIFT_REG_LEN(2)) u_d2 (
        .clk(clk), .srst_n(srst_n), .carry_in(d2_carry), .carry_out(d2_co),
        .x_re_i(d2_re), .x_im_i(d2_im), .z_re_o(d2_zre), .z_im_o(d2_zim)
    );

    fft_bfii #(.WIDTH(DW), .SHIFT_REG_LEN(1)) u_d1 (
        .clk(clk), .srst_n(srst_n), .carry_in(d1_carry), .carry_out(d1_co),
        .x_re_i(d1_re), .x_im_i(d1_im), .z_re_o(d1_zre), .z_im_o(d1_zim)
    );

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int unsigned LG = (g == 0) ? 1 : (g == 1) ? 4 : 256;
        fft_bfii #(.WIDTH(RW), .SHIFT_REG_LEN(LG)) u_r (
            .clk(clk), .srst_n(srst_n), .carry_in(r_carry), .carry_out(r_co[g]),
            .x_re_i(r_re), .x_im_i(r_im), .z_re_o(r_zre[g]), .z_im_o(r_zim[g])
        );
    end

    function automatic int wrap(input int v);
        logic signed [RW-1:0] t;
        t = RW'(v);
        return int'(t);
    endfunction

    function automatic vec_t mk(input logic c, input int re, input int im,
                                input logic co, input int zre, input int zim);
        vec_t v;
        v.carry = c; v.re = re; v.im = im; v.co = co; v.zre = zre; v.zim = zim;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic c, input int re, input int im);
        d2_carry = c; d2_re = DW'(re); d2_im = DW'(im);
        tick();
    endtask

    task automatic drive1(input logic c, input int re, input int im);
        d1_carry = c; d1_re = DW'(re); d1_im = DW'(im);
        tick();
    endtask

    // Per 4L frame: sums, differences, then the same on (c, -j*d), in emission order.
    task automatic build_exp(input int g, input int l);
        for (int b = 0; b < N; b += 4 * l) begin
            for (int n = 0; n < l; n++) begin
                int a_re, a_im, b_re, b_im, c_re, c_im, q_re, q_im;
                a_re = xin_re[b + n];         a_im = xin_im[b + n];
                b_re = xin_re[b + l + n];     b_im = xin_im[b + l + n];
                c_re = xin_re[b + 2 * l + n]; c_im = xin_im[b + 2 * l + n];
                q_re = xin_im[b + 3 * l + n];
                q_im = wrap(-xin_re[b + 3 * l + n]);
                exp_re[g][b + n]         = wrap(a_re + b_re);
                exp_im[g][b + n]         = wrap(a_im + b_im);
                exp_re[g][b + l + n]     = wrap(a_re - b_re);
                exp_im[g][b + l + n]     = wrap(a_im - b_im);
                exp_re[g][b + 2 * l + n] = wrap(c_re + q_re);
                exp_im[g][b + 2 * l + n] = wrap(c_im + q_im);
                exp_re[g][b + 3 * l + n] = wrap(c_re - q_re);
                exp_im[g][b + 3 * l + n] = wrap(c_im - q_im);
            end
        end
    endtask

    initial begin
        srst_n = 1'b0;
        d2_carry = 1'b0; d2_re = '0; d2_im = '0;
        d1_carry = 1'b0; d1_re = '0; d1_im = '0;
        r_carry = 1'b0;  r_re = '0;  r_im = '0;

        for (int i = 0; i < int'(N); i++) begin
            xin_re[i] = ($urandom_range(0, 15) == 0) ? -8388608 : wrap(int'($urandom));
            xin_im[i] = ($urandom_range(0, 15) == 0) ? -8388608 : wrap(int'($urandom));
        end
        for (int g = 0; g < 3; g++) begin
            build_exp(g, lens[g]);
            ridx[g] = 0;
        end

        // Constant (1,0) frame followed by two back-to-back impulse frames, L=2.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1'b1, 1, 0, i >= 2,
                             (i == 2 || i == 3) ? 2 : (i >= 6) ? 1 : 0,
                             (i >= 6) ? -1 : 0));
        end
        tbl.push_back(mk(1'b0, 0, 0, 1'b1, 1, 1));
        tbl.push_back(mk(1'b0, 0, 0, 1'b1, 1, 1));
        tbl.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0));
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                tbl.push_back(mk(1'b1, (i == 0) ? 5 : 0, (i == 0) ? 3 : 0,
                                 (f == 1) || (i >= 2),
                                 (i == 2 || i == 4) ? 5 : 0,
                                 (i == 2 || i == 4) ? 3 : 0));
            end
        end
        tbl.push_back(mk(1'b0, 0, 0, 1'b1, 0, 0));
        tbl.push_back(mk(1'b0, 0, 0, 1'b1, 0, 0));
        tbl.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0));
        tbl.push_back(mk(1'b0, 0, 0, 1'b0, 0, 0));

        repeat (4) tick();
        check("reset d2 co", int'(d2_co), 0);
        check("reset d2 zre", int'(d2_zre), 0);
        check("reset d2 zim", int'(d2_zim), 0);
        check("reset d1 co", int'(d1_co), 0);
        check("reset d1 zre", int'(d1_zre), 0);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset r%0d co", g), int'(r_co[g]), 0);
            check($sformatf("reset r%0d zre", g), int'(r_zre[g]), 0);
        end
        srst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive2(tbl[i].carry, tbl[i].re, tbl[i].im);
            check($sformatf("tbl[%0d] co", i), int'(d2_co), int'(tbl[i].co));
            check($sformatf("tbl[%0d] zre", i), int'(d2_zre), tbl[i].zre);
            check($sformatf("tbl[%0d] zim", i), int'(d2_zim), tbl[i].zim);
        end

        // One-cycle carry gap: the frame restarts as fill on the next sample.
        repeat (5) drive2(1'b1, 1, 0);
        check("gap co g4", int'(d2_co), 1);
        drive2(1'b0, 0, 0);
        check("gap co g5", int'(d2_co), 1);
        drive2(1'b1, 3, 1);
        check("gap co g6", int'(d2_co), 1);
        drive2(1'b1, 2, 2);
        check("gap co hole", int'(d2_co), 0);
        drive2(1'b1, 4, 0);
        check("gap co back", int'(d2_co), 1);
        check("gap sum0 re", int'(d2_zre), 7);
        check("gap sum0 im", int'(d2_zim), 1);
        drive2(1'b1, 1, 1);
        check("gap sum1 re", int'(d2_zre), 3);
        check("gap sum1 im", int'(d2_zim), 3);
        drive2(1'b1, 0, 0);
        check("gap diff0 re", int'(d2_zre), -1);
        check("gap diff0 im", int'(d2_zim), 1);
        drive2(1'b1, 0, 0);
        check("gap diff1 re", int'(d2_zre), 1);
        check("gap diff1 im", int'(d2_zim), 1);
        repeat (2) drive2(1'b1, 0, 0);
        repeat (4) drive2(1'b0, 0, 0);

        // Reset at ctr=5 with carry held high.
        repeat (5) drive2(1'b1, 1, 1);
        srst_n = 1'b0;
        drive2(1'b1, 1, 1);
        check("rst co", int'(d2_co), 0);
        check("rst zre", int'(d2_zre), 0);
        check("rst zim", int'(d2_zim), 0);
        srst_n = 1'b1;
        drive2(1'b1, 2, 0);
        check("rst co r1", int'(d2_co), 0);
        drive2(1'b1, 0, 3);
        check("rst co r2", int'(d2_co), 0);
        drive2(1'b1, 1, 1);
        check("rst co r3", int'(d2_co), 1);
        check("rst sum0 re", int'(d2_zre), 3);
        check("rst sum0 im", int'(d2_zim), 1);
        drive2(1'b1, 5, 5);
        check("rst sum1 re", int'(d2_zre), 5);
        check("rst sum1 im", int'(d2_zim), 8);
        repeat (4) drive2(1'b1, 0, 0);
        repeat (4) drive2(1'b0, 0, 0);

        // Rotation of the most negative value, L=1.
        repeat (3) drive1(1'b1, 0, 0);
        drive1(1'b1, -128, 0);
        check("rot co", int'(d1_co), 1);
        check("rot zre", int'(d1_zre), 0);
        check("rot zim", int'(d1_zim), -128);
        drive1(1'b0, 0, 0);
        check("rot diff co", int'(d1_co), 1);
        check("rot diff re", int'(d1_zre), 0);
        check("rot diff im", int'(d1_zim), -128);
        drive1(1'b0, 0, 0);
        check("rot co end", int'(d1_co), 0);

        // Random contiguous frames on all three lengths at once.
        for (int s = 0; s < int'(N) + 300; s++) begin
            r_carry = (s < int'(N));
            r_re = (s < int'(N)) ? RW'(xin_re[s]) : '0;
            r_im = (s < int'(N)) ? RW'(xin_im[s]) : '0;
            tick();
            for (int g = 0; g < 3; g++) begin
                if (r_co[g]) begin
                    if (ridx[g] < int'(N)) begin
                        check($sformatf("rnd L%0d re[%0d]", lens[g], ridx[g]),
                              int'(r_zre[g]), exp_re[g][ridx[g]]);
                        check($sformatf("rnd L%0d im[%0d]", lens[g], ridx[g]),
                              int'(r_zim[g]), exp_im[g][ridx[g]]);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL rnd L%0d overrun: got output %0d expected at most %0d",
                                 lens[g], ridx[g], N);
                    end
                    ridx[g]++;
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rnd L%0d count", lens[g]), ridx[g], int'(N));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
